// File: rtl/char_banner_seq_pkg.sv
// Shared definitions for the Pong text overlay: ASCII codes, effect modes,
// banner identifiers and the mode decoder used by the banner sequencer.
package char_banner_seq_pkg;

   typedef enum logic [6:0] {
      BLANK  = 7'h20,
      EXCL   = 7'h21,
      PERIOD = 7'h2E,
      DIG_0  = 7'h30, DIG_1, DIG_2, DIG_3, DIG_4,
      DIG_5, DIG_6, DIG_7, DIG_8, DIG_9,
      COLON  = 7'h3A,
      CAP_A  = 7'h41, CAP_B, CAP_C, CAP_D, CAP_E, CAP_F, CAP_G,
      CAP_H, CAP_I, CAP_J, CAP_K, CAP_L, CAP_M, CAP_N,
      CAP_O, CAP_P, CAP_Q, CAP_R, CAP_S, CAP_T, CAP_U,
      CAP_V, CAP_W, CAP_X, CAP_Y, CAP_Z
   } ascii_e;

   typedef enum logic [1:0] {
      MODE_STATIC = 2'b00,
      MODE_BLINK  = 2'b01,
      MODE_TYPE   = 2'b10
   } mode_e;

   typedef enum logic [1:0] {
      MSG_START    = 2'd0,
      MSG_BLUE_WIN = 2'd1,
      MSG_RED_WIN  = 2'd2,
      MSG_PAUSED   = 2'd3
   } msg_e;

   localparam int BANNER_LEN = 16;

   // The reserved encoding 2'b11 behaves exactly like static.
   function automatic mode_e decode_mode(input logic [1:0] m);
      case (m)
         2'b01:   return MODE_BLINK;
         2'b10:   return MODE_TYPE;
         default: return MODE_STATIC;
      endcase
   endfunction

endpackage

// File: rtl/char_banner_seq_table.sv
// Combinational banner text ROM: four fixed 16-character banners, column 0
// is the leftmost character.
module banner_text_table
   import char_banner_seq_pkg::*;
(
   input  logic [1:0] i_msg,
   input  logic [3:0] i_col,
   output logic [6:0] o_code
);

   localparam logic [127:0] TXT_START    = "START       GAME";
   localparam logic [127:0] TXT_BLUE_WIN = "BLUE PLAYER WINS";
   localparam logic [127:0] TXT_RED_WIN  = " RED PLAYER WINS";
   localparam logic [127:0] TXT_PAUSED   = "     PAUSED     ";

   logic [127:0] w_line;

   always_comb begin
      case (i_msg)
         MSG_START:    w_line = TXT_START;
         MSG_BLUE_WIN: w_line = TXT_BLUE_WIN;
         MSG_RED_WIN:  w_line = TXT_RED_WIN;
         default:      w_line = TXT_PAUSED;
      endcase
   end

   // String literals put column 0 in the top byte, so byte index = 15 - col.
   assign o_code = w_line[{~i_col, 3'b000} +: 7];

endmodule

// File: rtl/char_banner_seq.sv
// Banner sequencer: latches a banner and effect on msg_load, advances blink /
// typewriter state on frame_tick, and registers the ASCII code for char_xy.
module char_banner_seq
   import char_banner_seq_pkg::*;
#(
   parameter int COLS         = 16,
   parameter int BLINK_FRAMES = 30,
   parameter int TYPE_FRAMES  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    frame_tick,
   input  logic                    msg_load,
   input  logic [1:0]              msg_sel,
   input  logic [1:0]              mode,
   input  logic [$clog2(COLS)-1:0] char_xy,
   output logic [6:0]              char_code,
   output logic                    done,
   output logic [1:0]              cur_msg
);

   localparam int CNT_LIM = (BLINK_FRAMES > TYPE_FRAMES) ? BLINK_FRAMES : TYPE_FRAMES;
   localparam int CNT_W   = (CNT_LIM > 1) ? $clog2(CNT_LIM) : 1;
   localparam int RW      = $clog2(COLS + 1);

   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
   localparam logic [CNT_W-1:0] TYPE_LAST  = CNT_W'(TYPE_FRAMES - 1);
   localparam logic [RW-1:0]    REV_FULL   = RW'(COLS);

   mode_e            r_mode,  w_mode_nx;
   logic [1:0]       r_msg,   w_msg_nx;
   logic [CNT_W-1:0] r_cnt,   w_cnt_nx;
   logic             r_vis,   w_vis_nx;
   logic [RW-1:0]    r_rev,   w_rev_nx;
   logic             r_done,  w_done_nx;
   logic [6:0]       r_code,  w_code_nx;

   logic [6:0]  w_tbl_code;
   logic [31:0] w_xy_ext;
   logic [31:0] w_rev_ext;
   logic [RW-1:0] w_rev_inc;
   logic        w_show;

   banner_text_table u_table (
      .i_msg  (r_msg),
      .i_col  (char_xy[3:0]),
      .o_code (w_tbl_code)
   );

   assign w_xy_ext  = 32'(char_xy);
   assign w_rev_ext = 32'(r_rev);
   assign w_rev_inc = r_rev + RW'(1);

   // NOTE: every next-state value is given its hold value first, so no
   // branch leaves one unassigned and no latch is inferred.
   always_comb begin
      w_mode_nx = r_mode;
      w_msg_nx  = r_msg;
      w_cnt_nx  = r_cnt;
      w_vis_nx  = r_vis;
      w_rev_nx  = r_rev;
      w_done_nx = r_done;

      if (msg_load) begin
         w_msg_nx  = msg_sel;
         w_mode_nx = decode_mode(mode);
         w_cnt_nx  = '0;
         w_vis_nx  = 1'b1;
         w_rev_nx  = '0;
         w_done_nx = (decode_mode(mode) != MODE_TYPE);
      end else if (frame_tick) begin
         case (r_mode)
            MODE_BLINK: begin
               if (r_cnt == BLINK_LAST) begin
                  w_cnt_nx = '0;
                  w_vis_nx = ~r_vis;
               end else begin
                  w_cnt_nx = r_cnt + CNT_W'(1);
               end
            end
            MODE_TYPE: begin
               if (r_rev != REV_FULL) begin
                  if (r_cnt == TYPE_LAST) begin
                     w_cnt_nx  = '0;
                     w_rev_nx  = w_rev_inc;
                     w_done_nx = (w_rev_inc == REV_FULL);
                  end else begin
                     w_cnt_nx = r_cnt + CNT_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Columns past the banner width and unrevealed typewriter columns are blank.
   always_comb begin
      w_show = (w_xy_ext < 32'(BANNER_LEN)) && r_vis &&
               ((r_mode != MODE_TYPE) || (w_xy_ext < w_rev_ext));
      w_code_nx = w_show ? w_tbl_code : BLANK;
   end

   // NOTE: registers use non-blocking assignments so each one samples the
   // values present before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mode <= MODE_STATIC;
         r_msg  <= '0;
         r_cnt  <= '0;
         r_vis  <= 1'b1;
         r_rev  <= '0;
         r_done <= 1'b1;
         r_code <= BLANK;
      end else begin
         r_mode <= w_mode_nx;
         r_msg  <= w_msg_nx;
         r_cnt  <= w_cnt_nx;
         r_vis  <= w_vis_nx;
         r_rev  <= w_rev_nx;
         r_done <= w_done_nx;
         r_code <= w_code_nx;
      end
   end

   assign char_code = r_code;
   assign done      = r_done;
   assign cur_msg   = r_msg;

endmodule

// File: tb/tb_char_banner_seq.sv
// Self-checking bench: three parameterisations of char_banner_seq driven in
// lockstep, checked against directed tables and a frame-count reference model.
module tb_char_banner_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic       ld = 1'b0;
   logic [1:0] sel = '0;
   logic [1:0] md = '0;
   logic [4:0] xy = '0;

   logic [6:0] code_a, code_b, code_c;
   logic       done_a, done_b, done_c;
   logic [1:0] msg_a, msg_b, msg_c;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   char_banner_seq #(.COLS(16), .BLINK_FRAMES(2), .TYPE_FRAMES(1)) dut_a (
      .clk(clk), .reset(rst), .frame_tick(tick), .msg_load(ld), .msg_sel(sel),
      .mode(md), .char_xy(xy[3:0]), .char_code(code_a), .done(done_a), .cur_msg(msg_a));

   char_banner_seq #(.COLS(32), .BLINK_FRAMES(1), .TYPE_FRAMES(2)) dut_b (
      .clk(clk), .reset(rst), .frame_tick(tick), .msg_load(ld), .msg_sel(sel),
      .mode(md), .char_xy(xy), .char_code(code_b), .done(done_b), .cur_msg(msg_b));

   char_banner_seq #(.COLS(20), .BLINK_FRAMES(3), .TYPE_FRAMES(3)) dut_c (
      .clk(clk), .reset(rst), .frame_tick(tick), .msg_load(ld), .msg_sel(sel),
      .mode(md), .char_xy(xy), .char_code(code_c), .done(done_c), .cur_msg(msg_c));

   // Reference model: state is just "frames since load"; visibility and reveal
   // are derived from that count by division.
   string banners [4];
   int m_cols [3] = '{16, 32, 20};
   int m_blink[3] = '{2, 1, 3};
   int m_tf   [3] = '{1, 2, 3};
   int m_msg  [3];
   int m_md   [3];
   int m_ticks[3];

   function automatic int model_rev(int i);
      int r = m_ticks[i] / m_tf[i];
      return (r > m_cols[i]) ? m_cols[i] : r;
   endfunction

   function automatic logic [6:0] model_code(int i, int x);
      bit  vis;
      byte b;
      if (x >= 16) return 7'h20;
      vis = (m_md[i] != 1) || (((m_ticks[i] / m_blink[i]) % 2) == 0);
      if (!vis || (m_md[i] == 2 && x >= model_rev(i))) return 7'h20;
      b = banners[m_msg[i]][x];
      return b[6:0];
   endfunction

   function automatic logic model_done(int i);
      return (m_md[i] != 2) || (model_rev(i) == m_cols[i]);
   endfunction

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit rst_i, input bit ld_i, input bit tk_i,
                       input logic [1:0] sel_i, input logic [1:0] md_i,
                       input logic [4:0] xy_i);
      logic [6:0] exp_c [3];
      rst = rst_i; ld = ld_i; tick = tk_i; sel = sel_i; md = md_i; xy = xy_i;
      for (int i = 0; i < 3; i++) begin
         exp_c[i] = rst_i ? 7'h20 : model_code(i, (i == 0) ? int'(xy_i[3:0]) : int'(xy_i));
         if (rst_i) begin
            m_msg[i] = 0; m_md[i] = 0; m_ticks[i] = 0;
         end else if (ld_i) begin
            m_msg[i] = int'(sel_i);
            m_md[i]  = (md_i == 2'b11) ? 0 : int'(md_i);
            m_ticks[i] = 0;
         end else if (tk_i) begin
            m_ticks[i]++;
         end
      end
      @(posedge clk);
      #1;
      check("model_code_a", code_a, exp_c[0]);
      check("model_code_b", code_b, exp_c[1]);
      check("model_code_c", code_c, exp_c[2]);
      check("model_done_a", {6'b0, done_a}, {6'b0, model_done(0)});
      check("model_done_b", {6'b0, done_b}, {6'b0, model_done(1)});
      check("model_done_c", {6'b0, done_c}, {6'b0, model_done(2)});
      check("model_msg_a", {5'b0, msg_a}, 7'(m_msg[0]));
      check("model_msg_b", {5'b0, msg_b}, 7'(m_msg[1]));
      check("model_msg_c", {5'b0, msg_c}, 7'(m_msg[2]));
   endtask

   typedef struct {
      bit         rst, ld, tk;
      logic [1:0] sel, md;
      logic [4:0] xy;
      int         rep;
      logic [6:0] code;
      bit         done;
      logic [1:0] msg;
   } vec_t;

   vec_t tbl[$];

   initial begin
      banners[0] = "START       GAME";
      banners[1] = "BLUE PLAYER WINS";
      banners[2] = " RED PLAYER WINS";
      banners[3] = "     PAUSED     ";
      for (int i = 0; i < 3; i++) begin
         m_msg[i] = 0; m_md[i] = 0; m_ticks[i] = 0;
      end

      // Directed vectors for dut_a (COLS 16, blink 2, type 1).
      tbl.push_back('{1, 0, 0, 2'd0, 2'd0, 5'd0,  1, 7'h20, 1, 2'd0});
      tbl.push_back('{0, 0, 0, 2'd0, 2'd0, 5'd0,  1, 7'h53, 1, 2'd0});
      tbl.push_back('{0, 0, 0, 2'd0, 2'd0, 5'd12, 1, 7'h47, 1, 2'd0});
      tbl.push_back('{0, 0, 0, 2'd0, 2'd0, 5'd5,  1, 7'h20, 1, 2'd0});
      tbl.push_back('{0, 1, 0, 2'd1, 2'd1, 5'd0,  1, 7'h53, 1, 2'd1});
      tbl.push_back('{0, 0, 0, 2'd0, 2'd0, 5'd0,  1, 7'h42, 1, 2'd1});
      tbl.push_back('{0, 0, 1, 2'd0, 2'd0, 5'd0,  2, 7'h42, 1, 2'd1});
      tbl.push_back('{0, 0, 0, 2'd0, 2'd0, 5'd0,  1, 7'h20, 1, 2'd1});
      tbl.push_back('{0, 0, 1, 2'd0, 2'd0, 5'd0,  2, 7'h20, 1, 2'd1});
      tbl.push_back('{0, 0, 0, 2'd0, 2'd0, 5'd0,  1, 7'h42, 1, 2'd1});
      tbl.push_back('{0, 1, 0, 2'd3, 2'd2, 5'd0,  1, 7'h42, 0, 2'd3});
      tbl.push_back('{0, 0, 0, 2'd0, 2'd0, 5'd6,  1, 7'h20, 0, 2'd3});
      tbl.push_back('{0, 0, 1, 2'd0, 2'd0, 5'd5,  5, 7'h20, 0, 2'd3});
      tbl.push_back('{0, 0, 0, 2'd0, 2'd0, 5'd5,  1, 7'h20, 0, 2'd3});
      tbl.push_back('{0, 0, 1, 2'd0, 2'd0, 5'd5,  1, 7'h20, 0, 2'd3});
      tbl.push_back('{0, 0, 0, 2'd0, 2'd0, 5'd5,  1, 7'h50, 0, 2'd3});
      tbl.push_back('{0, 0, 1, 2'd0, 2'd0, 5'd5,  9, 7'h50, 0, 2'd3});
      tbl.push_back('{0, 0, 1, 2'd0, 2'd0, 5'd10, 1, 7'h44, 1, 2'd3});
      tbl.push_back('{0, 0, 1, 2'd0, 2'd0, 5'd10, 3, 7'h44, 1, 2'd3});

      @(negedge clk);
      foreach (tbl[k]) begin
         for (int r = 0; r < tbl[k].rep; r++)
            step(tbl[k].rst, tbl[k].ld, tbl[k].tk, tbl[k].sel, tbl[k].md, tbl[k].xy);
         check($sformatf("tbl%0d_code", k), code_a, tbl[k].code);
         check($sformatf("tbl%0d_done", k), {6'b0, done_a}, {6'b0, tbl[k].done});
         check($sformatf("tbl%0d_msg", k), {5'b0, msg_a}, {5'b0, tbl[k].msg});
      end

      // Load coincident with tick on dut_b (blink 1): tick is discarded.
      step(0, 1, 1, 2'd0, 2'd1, 5'd0);
      check("coinc_done_b", {6'b0, done_b}, 7'h01);
      step(0, 0, 0, 2'd0, 2'd0, 5'd0);
      check("coinc_vis_b", code_b, 7'h53);
      step(0, 0, 1, 2'd0, 2'd0, 5'd0);
      check("coinc_tick_b", code_b, 7'h53);
      step(0, 0, 0, 2'd0, 2'd0, 5'd0);
      check("coinc_blank_b", code_b, 7'h20);

      // Wide display: blank columns beyond the banner, long typewriter run.
      step(0, 1, 0, 2'd2, 2'd0, 5'd0);
      step(0, 0, 0, 2'd0, 2'd0, 5'd15);
      check("wide_col15_b", code_b, 7'h53);
      step(0, 0, 0, 2'd0, 2'd0, 5'd20);
      check("wide_col20_b", code_b, 7'h20);
      check("wide_col20_c", code_c, 7'h20);
      step(0, 1, 0, 2'd2, 2'd2, 5'd0);
      for (int t = 0; t < 63; t++) step(0, 0, 1, 2'd0, 2'd0, 5'd15);
      check("wide_done_early_b", {6'b0, done_b}, 7'h00);
      step(0, 0, 1, 2'd0, 2'd0, 5'd15);
      check("wide_done_b", {6'b0, done_b}, 7'h01);
      step(0, 0, 1, 2'd0, 2'd0, 5'd15);
      check("wide_done_hold_b", {6'b0, done_b}, 7'h01);

      // Reset in the middle of a typewriter reveal on dut_a.
      step(0, 1, 0, 2'd1, 2'd2, 5'd0);
      for (int t = 0; t < 7; t++) step(0, 0, 1, 2'd0, 2'd0, 5'd3);
      check("mid_done_a", {6'b0, done_a}, 7'h00);
      step(1, 1, 1, 2'd2, 2'd1, 5'd0);
      check("rst_code_a", code_a, 7'h20);
      check("rst_msg_a", {5'b0, msg_a}, 7'h00);
      check("rst_done_a", {6'b0, done_a}, 7'h01);
      step(0, 0, 0, 2'd0, 2'd0, 5'd0);
      check("rst_after_a", code_a, 7'h53);

      // Randomised traffic against the reference model.
      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/char_banner_seq.md
Name: char_banner_seq

Overview:
- Parametrised, sequenced successor to the fixed 16-column text-overlay ROM used by the Pong text renderer.
- Holds four 16-character banners and takes a column index from the text pixel generator.
- Returns a registered 7-bit ASCII code to the font ROM.
- Adds per-frame effects: static, blink and typewriter reveal. Banner and effect are selected at run time by the game FSM.

Parameters:
- COLS, 16: display columns per banner; must be at least 16. Columns 16..COLS-1 are always blank.
- BLINK_FRAMES, 30: frames per blink half-period; must be at least 1.
- TYPE_FRAMES, 4: frames between successive typewriter character reveals; must be at least 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse, once per video frame.
- msg_load  in  1  one-cycle pulse; latches msg_sel and mode.
- msg_sel  in  2  banner index.
- mode  in  2  effect: 00 static, 01 blink, 10 typewriter, 11 reserved (treated as static).
- char_xy  in  $clog2(COLS)  column index.
- char_code  out  7  ASCII code, registered.
- done  out  1  high when the effect is fully shown (static, blink, or typewriter complete).
- cur_msg  out  2  currently latched banner index.

Behaviour:
- Reset is synchronous and active-high, applied on the clk edge. Reset values:
  - char_code = 7'h20; cur_msg = 0; mode register = static.
  - visible = 1; frame counter = 0; reveal count = 0; done = 1.
- Banner text, 16 characters each, column 0 first:
  - 0 = "START       GAME"
  - 1 = "BLUE PLAYER WINS"
  - 2 = " RED PLAYER WINS"
  - 3 = "     PAUSED     "
- Output path, latency exactly one cycle from char_xy:
  - char_code <= table[cur_msg][char_xy] when all hold: char_xy < 16, visible = 1, and (mode != typewriter or char_xy < reveal).
  - Otherwise char_code <= 7'h20.
- msg_load on a clock edge:
  - cur_msg <= msg_sel; mode <= mode input.
  - frame counter <= 0; visible <= 1; reveal <= 0.
  - done <= 0 if the new mode is typewriter, else 1.
  - The new banner appears on char_code from the following cycle.
- msg_load and frame_tick in the same cycle: msg_load wins and the tick is discarded.
- frame_tick without msg_load:
  - Static: no state change; the counter holds at 0.
  - Blink: the counter increments. At BLINK_FRAMES-1 it wraps to 0 and toggles visible.
  - Typewriter, reveal < COLS: the counter increments. At TYPE_FRAMES-1 it wraps to 0 and reveal increments.
  - Typewriter, reveal = COLS: no change; done = 1.
- Typewriter saturation:
  - reveal is $clog2(COLS+1) bits wide and saturates at COLS.
  - done is registered and rises on the same edge that reveal becomes COLS.
  - Reveal continues through the blank columns 16..COLS-1, so done asserts COLS reveal periods after load.
- Out-of-range index: char_xy >= 16 (including values >= COLS when COLS is not a power of two) outputs 7'h20.
- Reset mid-effect: reset overrides load and tick and returns to the reset values on the next edge.
- The frame counter is sized for max(BLINK_FRAMES, TYPE_FRAMES) and never exceeds (limit - 1).

Decomposition:
- Shared package (e.g. pong_text_pkg):
  - ASCII character constants (BLANK, CAP_A..CAP_Z, digits, punctuation).
  - Mode encodings MODE_STATIC / MODE_BLINK / MODE_TYPE.
  - Banner IDs MSG_START / MSG_BLUE_WIN / MSG_RED_WIN / MSG_PAUSED.
- One natural sub-module: banner_text_table, purely combinational, (msg[1:0], col[3:0]) -> code[6:0].
- The effect FSM, counters and output register stay in char_banner_seq.

Test Plan:
1. Reset, then char_xy = 0 -> next cycle char_code = 7'h53 ('S'). char_xy = 12 -> 7'h47 ('G'). char_xy = 5 -> 7'h20. done = 1 throughout.
2. BLINK_FRAMES = 2; load msg 1, mode 01; char_xy = 0 -> 7'h42 ('B').
   - After 2 frame_ticks -> 7'h20.
   - After 2 more -> 7'h42.
   - done stays 1.
3. TYPE_FRAMES = 1, COLS = 16; load msg 3, mode 10 -> done = 0 and all columns 7'h20.
   - After 5 ticks, char_xy = 5 -> 7'h20.
   - After the 6th tick -> 7'h50 ('P').
   - After 16 ticks -> done = 1; extra ticks change nothing.
4. msg_load coincident with frame_tick, BLINK_FRAMES = 1: visible stays 1 and the counter stays 0; char_code remains non-blank for one further tick period.
5. COLS = 32: char_xy = 15 on msg 2 -> 7'h53 ('S'); char_xy = 20 -> 7'h20. Typewriter done asserts only after 32 reveal periods.
6. reset asserted mid-typewriter (reveal = 7) -> next cycle char_code = 7'h20, cur_msg = 0, done = 1. Then char_xy = 0 -> 7'h53.
